// File: rtl/mcam_mr.sv
// mcam_mr: multi-region memory access controller.
//
// It sits between the data-memory read path and the CPU. Each region i pairs
// a code window [LOW_CODE[i]..HIGH_CODE[i]] with a safe data window
// [LOW_SAFE[i]..HIGH_SAFE[i]]. Only code from region i may touch its safe data.
// That code may be entered only at LOW_CODE[i].
// On a violation the block blanks read data, logs the first cause, and raises
// a reset request of RST_CYCLES cycles.
//
// Ports:
//   i_mclk, i_reset       clock, synchronous active-high reset
//   i_mem_addr, i_mem_en  data access address / valid
//   i_mem_din             read data from memory
//   i_ins_addr            current instruction address
//   i_disable_debug       1 = enforcement off (tracking and logging continue)
//   i_viol_clr            clears the sticky violation log
//   o_mem_dout            read data to CPU (zero while blanked)
//   o_in_safe_area        per-region allow flags
//   o_rst_req             reset request pulse
//   o_viol_valid/_type/_region/_addr  first logged violation
//   o_viol_cnt            saturating violation-cycle count
//
// Optional feature macro: MCAM_VIOL_CNT_EN (enables o_viol_cnt counter,
// otherwise o_viol_cnt is tied to zero).

// Per-region window compares. All addresses are already 16 bits wide.
module mcam_mr_win #(
    parameter logic [15:0] LS = 16'h0200,
    parameter logic [15:0] HS = 16'h027F,
    parameter logic [15:0] LC = 16'h0100,
    parameter logic [15:0] HC = 16'h01FF
) (
    input  logic [15:0] i_mem_addr,
    input  logic [15:0] i_ins_addr,
    input  logic        i_mem_en,
    input  logic        i_allow,
    output logic        o_in_code,
    output logic        o_at_entry,
    output logic        o_data_viol,
    output logic        o_entry_viol
);
    logic w_in_safe;

    assign w_in_safe    = (i_mem_addr >= LS) && (i_mem_addr <= HS);
    assign o_in_code    = (i_ins_addr >= LC) && (i_ins_addr <= HC);
    assign o_at_entry   = (i_ins_addr == LC);
    // allow is the registered flag, so an access in the same cycle as the
    // entry fetch still counts as a violation.
    assign o_data_viol  = i_mem_en & w_in_safe & ~i_allow;
    assign o_entry_viol = o_in_code & ~o_at_entry & ~i_allow;
endmodule

module mcam_mr #(
    parameter int                      N_REGIONS     = 2,
    parameter int                      SIZE_MEM_ADDR = 15,
    parameter logic [16*N_REGIONS-1:0] LOW_SAFE      = {16'h0280, 16'h0200},
    parameter logic [16*N_REGIONS-1:0] HIGH_SAFE     = {16'h02FF, 16'h027F},
    parameter logic [16*N_REGIONS-1:0] LOW_CODE      = {16'h0300, 16'h0100},
    parameter logic [16*N_REGIONS-1:0] HIGH_CODE     = {16'h03FF, 16'h01FF},
    parameter int                      RST_CYCLES    = 4
) (
    input  logic                     i_mclk,
    input  logic                     i_reset,
    input  logic [SIZE_MEM_ADDR:0]   i_mem_addr,
    input  logic                     i_mem_en,
    input  logic [15:0]              i_mem_din,
    input  logic [15:0]              i_ins_addr,
    input  logic                     i_disable_debug,
    input  logic                     i_viol_clr,
    output logic [15:0]              o_mem_dout,
    output logic [N_REGIONS-1:0]     o_in_safe_area,
    output logic                     o_rst_req,
    output logic                     o_viol_valid,
    output logic                     o_viol_type,
    output logic [2:0]               o_viol_region,
    output logic [15:0]              o_viol_addr,
    output logic [7:0]               o_viol_cnt
);
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RST_CYCLES - 1);

    typedef enum logic {S_IDLE, S_PULSE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   w_go_pulse;

    logic [15:0]            w_addr16;
    logic [N_REGIONS-1:0]   r_allow;
    logic [N_REGIONS-1:0]   w_in_code, w_at_entry, w_dv, w_ev;
    logic                   w_viol_now;
    logic                   w_vtype;
    logic [2:0]             w_vreg;
    logic [15:0]            w_vaddr;

    logic                   r_viol_valid;
    logic                   r_viol_type;
    logic [2:0]             r_viol_region;
    logic [15:0]            r_viol_addr;

    assign w_addr16 = 16'(i_mem_addr);

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_win
        mcam_mr_win #(
            .LS(LOW_SAFE [16*g +: 16]),
            .HS(HIGH_SAFE[16*g +: 16]),
            .LC(LOW_CODE [16*g +: 16]),
            .HC(HIGH_CODE[16*g +: 16])
        ) u_win (
            .i_mem_addr  (w_addr16),
            .i_ins_addr  (i_ins_addr),
            .i_mem_en    (i_mem_en),
            .i_allow     (r_allow[g]),
            .o_in_code   (w_in_code[g]),
            .o_at_entry  (w_at_entry[g]),
            .o_data_viol (w_dv[g]),
            .o_entry_viol(w_ev[g])
        );
    end

    assign w_viol_now = (|w_dv) | (|w_ev);

    // Walk from the highest region down so the lowest violated region wins.
    // Within a region a data violation beats an entry violation.
    always_comb begin
        w_vtype = 1'b0;
        w_vreg  = 3'd0;
        w_vaddr = 16'h0000;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (w_dv[i]) begin
                w_vtype = 1'b0;
                w_vreg  = 3'(i);
                w_vaddr = w_addr16;
            end else if (w_ev[i]) begin
                w_vtype = 1'b1;
                w_vreg  = 3'(i);
                w_vaddr = i_ins_addr;
            end
        end
    end

    // Allow flags. Starting a pulse wipes them, even if this cycle fetches an entry word.
    always_ff @(posedge i_mclk) begin
        if (i_reset || w_go_pulse) begin
            r_allow <= '0;
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                if (w_at_entry[i])
                    r_allow[i] <= 1'b1;
                else if (!w_in_code[i])
                    r_allow[i] <= 1'b0;
            end
        end
    end

    // Reset-request FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go_pulse  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_viol_now && !i_disable_debug) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = CNT_INIT;
                    w_go_pulse  = 1'b1;
                end
            end
            S_PULSE: begin
                if (i_disable_debug || r_cnt == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sticky log: the first violation wins. A clear in the same cycle as a new violation logs the new one.
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_viol_valid  <= 1'b0;
            r_viol_type   <= 1'b0;
            r_viol_region <= 3'd0;
            r_viol_addr   <= 16'h0000;
        end else if (w_viol_now && (!r_viol_valid || i_viol_clr)) begin
            r_viol_valid  <= 1'b1;
            r_viol_type   <= w_vtype;
            r_viol_region <= w_vreg;
            r_viol_addr   <= w_vaddr;
        end else if (i_viol_clr) begin
            r_viol_valid  <= 1'b0;
        end
    end

`ifdef MCAM_VIOL_CNT_EN
    logic [7:0] r_viol_cnt;
    always_ff @(posedge i_mclk) begin
        if (i_reset)
            r_viol_cnt <= 8'h00;
        else if (w_viol_now && r_viol_cnt != 8'hFF)
            r_viol_cnt <= r_viol_cnt + 8'd1;
    end
    assign o_viol_cnt = r_viol_cnt;
`else
    assign o_viol_cnt = 8'h00;
`endif

    assign o_rst_req      = (r_state == S_PULSE) & ~i_disable_debug;
    assign o_mem_dout     = ((w_viol_now || r_state == S_PULSE) && !i_disable_debug)
                            ? 16'h0000 : i_mem_din;
    assign o_in_safe_area = r_allow;
    assign o_viol_valid   = r_viol_valid;
    assign o_viol_type    = r_viol_type;
    assign o_viol_region  = r_viol_region;
    assign o_viol_addr    = r_viol_addr;
endmodule

// File: tb/tb_mcam_mr.sv
module tb_mcam_mr;
    localparam int SEL_DOUT = 0, SEL_SAFE = 1, SEL_RST = 2, SEL_VV = 3,
                   SEL_VTYPE = 4, SEL_VREG = 5, SEL_VADDR = 6, SEL_VCNT = 7;
    localparam int TIMEOUT_CYC = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr, mem_din, ins_addr;
    logic        mem_en, dd, clr;
    logic [15:0] dout;
    logic [1:0]  safe;
    logic        rst_req, vv, vtype;
    logic [2:0]  vreg;
    logic [15:0] vaddr;
    logic [7:0]  vcnt;
    logic        done = 1'b0;

    typedef struct {
        string       nm;
        int          sel;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mcam_mr dut (
        .i_mclk         (clk),
        .i_reset        (rst),
        .i_mem_addr     (mem_addr),
        .i_mem_en       (mem_en),
        .i_mem_din      (mem_din),
        .i_ins_addr     (ins_addr),
        .i_disable_debug(dd),
        .i_viol_clr     (clr),
        .o_mem_dout     (dout),
        .o_in_safe_area (safe),
        .o_rst_req      (rst_req),
        .o_viol_valid   (vv),
        .o_viol_type    (vtype),
        .o_viol_region  (vreg),
        .o_viol_addr    (vaddr),
        .o_viol_cnt     (vcnt)
    );

    function automatic logic [15:0] got(int sel);
        case (sel)
            SEL_DOUT:  return dout;
            SEL_SAFE:  return {14'h0, safe};
            SEL_RST:   return {15'h0, rst_req};
            SEL_VV:    return {15'h0, vv};
            SEL_VTYPE: return {15'h0, vtype};
            SEL_VREG:  return {13'h0, vreg};
            SEL_VADDR: return vaddr;
            default:   return {8'h0, vcnt};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [15:0] g;
            e = q.pop_front();
            g = got(e.sel);
            checks++;
            if (g !== e.v) begin
                errors++;
                $display("FAIL %s got=%h exp=%h t=%0t", e.nm, g, e.v, $time);
            end
        end
    end

    initial begin
        repeat (TIMEOUT_CYC) @(posedge clk);
        if (!done) begin
            errors++;
            $display("FAIL timeout after %0d cycles t=%0t", TIMEOUT_CYC, $time);
            $finish;
        end
    end

    task automatic expect_v(string nm, int sel, logic [15:0] v);
        exp_t e;
        e.nm = nm; e.sel = sel; e.v = v;
        q.push_back(e);
    endtask

    task automatic cyc(logic [15:0] ia, logic en, logic [15:0] ma,
                       logic [15:0] din, logic d, logic c);
        @(posedge clk);
        #1;
        ins_addr = ia; mem_en = en; mem_addr = ma; mem_din = din;
        dd = d; clr = c;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(16'h0050, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        ins_addr = 16'h0050; mem_en = 1'b0; mem_addr = 16'h0; mem_din = 16'h5555;
        dd = 1'b0; clr = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    function automatic logic [15:0] cnt_exp(int n);
`ifdef MCAM_VIOL_CNT_EN
        return (n > 255) ? 16'h00FF : 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    initial begin
        rst = 1'b1; ins_addr = 16'h0050; mem_en = 1'b0; mem_addr = 16'h0;
        mem_din = 16'h5555; dd = 1'b0; clr = 1'b0;

        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rst_req !== 1'b0 || vv !== 1'b0 || safe !== 2'b00 ||
            vcnt !== 8'h00 || dout !== 16'h5555) begin
            errors++;
            $display("FAIL rst_direct rst_req=%b vv=%b safe=%b cnt=%h dout=%h t=%0t",
                     rst_req, vv, safe, vcnt, dout, $time);
        end
        @(posedge clk); #1;
        expect_v("rst_safe", SEL_SAFE, 16'h0);
        expect_v("rst_req0", SEL_RST, 16'h0);
        expect_v("rst_vv", SEL_VV, 16'h0);
        expect_v("rst_vtype", SEL_VTYPE, 16'h0);
        expect_v("rst_vreg", SEL_VREG, 16'h0);
        expect_v("rst_vaddr", SEL_VADDR, 16'h0);
        expect_v("rst_vcnt", SEL_VCNT, 16'h0);
        expect_v("rst_dout", SEL_DOUT, 16'h5555);
        rst = 1'b0;

        cyc(16'h0100, 1'b0, 16'h0000, 16'h1111, 1'b0, 1'b0);
        expect_v("t1_dout_entry", SEL_DOUT, 16'h1111);
        cyc(16'h0104, 1'b1, 16'h0210, 16'hA5A5, 1'b0, 1'b0);
        expect_v("t1_safe", SEL_SAFE, 16'h1);
        expect_v("t1_dout", SEL_DOUT, 16'hA5A5);
        cyc(16'h0050, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0);
        expect_v("t1_safe_hold", SEL_SAFE, 16'h1);
        expect_v("t1_rst", SEL_RST, 16'h0);
        expect_v("t1_vv", SEL_VV, 16'h0);
        idle(1);
        expect_v("t1_safe_clr", SEL_SAFE, 16'h0);

        do_reset();
        cyc(16'h0050, 1'b1, 16'h0290, 16'h1234, 1'b0, 1'b0);
        expect_v("t2_blank", SEL_DOUT, 16'h0000);
        expect_v("t2_rst_pre", SEL_RST, 16'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            expect_v($sformatf("t2_rst_%0d", i), SEL_RST, 16'h1);
            expect_v($sformatf("t2_pblank_%0d", i), SEL_DOUT, 16'h0000);
        end
        idle(1);
        expect_v("t2_rst_end", SEL_RST, 16'h0);
        expect_v("t2_dout_end", SEL_DOUT, 16'h5555);
        expect_v("t2_vv", SEL_VV, 16'h1);
        expect_v("t2_vtype", SEL_VTYPE, 16'h0);
        expect_v("t2_vreg", SEL_VREG, 16'h1);
        expect_v("t2_vaddr", SEL_VADDR, 16'h0290);
        expect_v("t2_vcnt", SEL_VCNT, cnt_exp(1));
        cyc(16'h0050, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b1);
        idle(1);
        expect_v("t2_vv_clr", SEL_VV, 16'h0);
        expect_v("t2_vcnt_noclr", SEL_VCNT, cnt_exp(1));

        do_reset();
        cyc(16'h0120, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        expect_v("t3_blank", SEL_DOUT, 16'h0000);
        idle(1);
        expect_v("t3_rst", SEL_RST, 16'h1);
        expect_v("t3_vtype", SEL_VTYPE, 16'h1);
        expect_v("t3_vreg", SEL_VREG, 16'h0);
        expect_v("t3_vaddr", SEL_VADDR, 16'h0120);
        expect_v("t3_safe", SEL_SAFE, 16'h0);
        idle(3);
        expect_v("t3_rst_last", SEL_RST, 16'h1);
        idle(1);
        expect_v("t3_rst_end", SEL_RST, 16'h0);
        cyc(16'h0300, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0);
        cyc(16'h0300, 1'b1, 16'h0210, 16'h5555, 1'b0, 1'b0);
        expect_v("t3_safe_r1", SEL_SAFE, 16'h2);
        cyc(16'h0300, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0);
        expect_v("t3_safe_wiped", SEL_SAFE, 16'h0);
        idle(5);

        do_reset();
        cyc(16'h0050, 1'b1, 16'h0290, 16'h1234, 1'b1, 1'b0);
        expect_v("t4_dout", SEL_DOUT, 16'h1234);
        cyc(16'h0050, 1'b1, 16'h0200, 16'h4321, 1'b1, 1'b0);
        expect_v("t4_rst", SEL_RST, 16'h0);
        expect_v("t4_vv", SEL_VV, 16'h1);
        expect_v("t4_dout2", SEL_DOUT, 16'h4321);
        cyc(16'h0050, 1'b0, 16'h0000, 16'h5555, 1'b1, 1'b0);
        expect_v("t4_first_wins", SEL_VADDR, 16'h0290);
        cyc(16'h0050, 1'b1, 16'h0201, 16'h5555, 1'b1, 1'b1);
        cyc(16'h0050, 1'b0, 16'h0000, 16'h5555, 1'b1, 1'b0);
        expect_v("t4_clr_new_addr", SEL_VADDR, 16'h0201);
        expect_v("t4_clr_new_reg", SEL_VREG, 16'h0);
        expect_v("t4_clr_vv", SEL_VV, 16'h1);
        expect_v("t4_rst_dd", SEL_RST, 16'h0);
        cyc(16'h0050, 1'b1, 16'h0290, 16'h5555, 1'b0, 1'b0);
        idle(1);
        expect_v("t4_pulse_on", SEL_RST, 16'h1);
        cyc(16'h0050, 1'b0, 16'h0000, 16'h6666, 1'b1, 1'b0);
        expect_v("t4_dd_gate", SEL_RST, 16'h0);
        expect_v("t4_dd_dout", SEL_DOUT, 16'h6666);
        idle(1);
        expect_v("t4_dd_idle", SEL_RST, 16'h0);

        do_reset();
        cyc(16'h0100, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0);
        cyc(16'h0300, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0);
        expect_v("t5_safe01", SEL_SAFE, 16'h1);
        cyc(16'h0300, 1'b1, 16'h0210, 16'h7777, 1'b0, 1'b0);
        expect_v("t5_safe10", SEL_SAFE, 16'h2);
        expect_v("t5_blank", SEL_DOUT, 16'h0000);
        idle(1);
        expect_v("t5_vv", SEL_VV, 16'h1);
        expect_v("t5_vtype", SEL_VTYPE, 16'h0);
        expect_v("t5_vreg", SEL_VREG, 16'h0);
        expect_v("t5_vaddr", SEL_VADDR, 16'h0210);
        idle(5);
        do_reset();
        cyc(16'h0120, 1'b1, 16'h0290, 16'h5555, 1'b1, 1'b0);
        idle(1);
        expect_v("t5_prio_type", SEL_VTYPE, 16'h1);
        expect_v("t5_prio_reg", SEL_VREG, 16'h0);
        expect_v("t5_prio_addr", SEL_VADDR, 16'h0120);
        do_reset();
        cyc(16'h0320, 1'b1, 16'h0290, 16'h5555, 1'b1, 1'b0);
        idle(1);
        expect_v("t5_dbe_type", SEL_VTYPE, 16'h0);
        expect_v("t5_dbe_reg", SEL_VREG, 16'h1);
        expect_v("t5_dbe_addr", SEL_VADDR, 16'h0290);

        do_reset();
        for (int i = 0; i < 300; i++) cyc(16'h0050, 1'b1, 16'h0290, 16'h5555, 1'b1, 1'b0);
        cyc(16'h0050, 1'b0, 16'h0000, 16'h5555, 1'b1, 1'b0);
        expect_v("t6_cnt_sat", SEL_VCNT, cnt_exp(300));
        cyc(16'h0050, 1'b0, 16'h0000, 16'h5555, 1'b1, 1'b1);
        idle(1);
        expect_v("t6_cnt_keep", SEL_VCNT, cnt_exp(300));
        do_reset();
        cyc(16'h0050, 1'b1, 16'h0290, 16'h5555, 1'b0, 1'b0);
        idle(1);
        expect_v("t6_p1", SEL_RST, 16'h1);
        idle(1);
        expect_v("t6_p2", SEL_RST, 16'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        expect_v("t6_abort", SEL_RST, 16'h0);
        expect_v("t6_abort_vv", SEL_VV, 16'h0);
        expect_v("t6_abort_cnt", SEL_VCNT, 16'h0);
        idle(1);
        expect_v("t6_stay_idle", SEL_RST, 16'h0);

        idle(2);
        done = 1'b1;
        if (errors != 0 || checks < 12)
            $display("FAIL summary CHECKS %0d ERRORS %0d", checks, errors);
        else
            $display("PASS CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcam_mr.md
Name: mcam_mr

Overview:
- Multi-region successor of the memory access controller; sits between the data-memory read path and the CPU.
- Supports N independent protected regions. Each region pairs a code window, entered only at its first word, with a safe data window that only that code may touch.
- On a violation: blanks read data, logs the cause, and drives a timed reset-request pulse through an FSM.

Parameters:
N_REGIONS, 2, number of protected regions (1..8)
SIZE_MEM_ADDR, 15, msb index of mem_addr
LOW_SAFE, {16'h0280,16'h0200}, packed 16*N_REGIONS; region i low safe data addr at [16*i+15:16*i]
HIGH_SAFE, {16'h02FF,16'h027F}, packed; region i high safe data addr (inclusive)
LOW_CODE, {16'h0300,16'h0100}, packed; region i code low addr = sole legal entry point
HIGH_CODE, {16'h03FF,16'h01FF}, packed; region i code high addr (inclusive)
RST_CYCLES, 4, rst_req pulse length in cycles (>=1)

Ports:
mclk  in  1  clock
reset  in  1  synchronous active-high reset
mem_addr  in  SIZE_MEM_ADDR+1  data memory address
mem_en  in  1  data access valid this cycle
mem_din  in  16  read data from memory
ins_addr  in  16  current instruction address
disable_debug  in  1  high = enforcement off (logging only)
viol_clr  in  1  clears violation log
mem_dout  out  16  read data to CPU (blanked on violation)
in_safe_area  out  N_REGIONS  per-region allow flag
rst_req  out  1  reset request pulse
viol_valid  out  1  violation logged (sticky)
viol_type  out  1  0 = illegal data access, 1 = illegal code entry
viol_region  out  3  index of violated region
viol_addr  out  16  mem_addr (type 0) or ins_addr (type 1) of logged violation
viol_cnt  out  8  violation count (see optional feature)

Behaviour:
- Reset (synchronous, active-high): allow[*]=0, FSM=IDLE, rst_req=0, viol_valid=0, viol_type=0, viol_region=0, viol_addr=0, viol_cnt=0. mem_dout = mem_din (combinational) after reset.
- Windows are inclusive compares, zero-extended to 16 bits. Overlapping regions resolve to the lowest index.
- allow[i] next state:
  - set if ins_addr==LOW_CODE[i];
  - else cleared if ins_addr is outside code window i;
  - else held.
  - All allow cleared on the IDLE->PULSE transition.
- Combinational violations per cycle, using the registered allow:
  - data_viol[i] = mem_en & mem_addr in safe window i & ~allow[i].
  - entry_viol[i] = ins_addr in code window i & ins_addr!=LOW_CODE[i] & ~allow[i] (jump into the middle of a region).
  - An access in the same cycle as the entry fetch still violates, because allow is not yet set.
- viol_now = any data_viol | any entry_viol. If both kinds are present, the lowest violated region is reported, and data beats entry within that region.
- mem_dout = 16'h0000 when (viol_now | FSM==PULSE) & ~disable_debug; otherwise mem_din. Zero latency, combinational.
- FSM states:
  - IDLE: if viol_now & ~disable_debug, go to PULSE at the next edge and load the counter with RST_CYCLES-1.
  - PULSE: rst_req=1; the counter decrements each cycle; return to IDLE when the counter reaches 0. rst_req is high for exactly RST_CYCLES cycles, starting the cycle after detection.
  - Violations during PULSE do not extend or restart the pulse.
- Violation log:
  - On viol_now while viol_valid==0: latch type/region/addr and set viol_valid. This applies even when disable_debug=1.
  - First violation wins; later ones do not overwrite.
  - viol_clr clears viol_valid next edge; if viol_now is in the same cycle, the new violation is logged instead.
- disable_debug=1: no blanking, no rst_req, FSM stays in IDLE. allow tracking and logging continue.
- disable_debug rising during PULSE: rst_req drops immediately (gated output) and the FSM returns to IDLE next edge.
- Reset asserted mid-PULSE aborts the pulse (FSM=IDLE, rst_req=0 next edge).

Optional Feature:
MCAM_VIOL_CNT_EN
- Defined: viol_cnt is an 8-bit saturating counter, +1 on each cycle with viol_now=1, holding at 8'hFF. Cleared only by reset, not by viol_clr.
- Undefined: no counter logic; viol_cnt tied to 8'h00.

Test Plan:
1. Default params; ins_addr 0x0100 then 0x0104; mem_en=1, mem_addr 0x0210 in the second cycle -> in_safe_area=2'b01, mem_dout=mem_din, rst_req stays 0, viol_valid=0.
2. ins_addr 0x0050, mem_en=1, mem_addr 0x0290 -> mem_dout=0 that cycle; rst_req=1 for exactly 4 cycles starting next edge; viol_valid=1, type=0, region=1, viol_addr=0x0290.
3. From outside, ins_addr jumps to 0x0120 -> entry violation: type=1, region=0, viol_addr=0x0120, 4-cycle rst_req pulse, allow all 0.
4. disable_debug=1, repeat scenario 2 -> mem_dout=mem_din, rst_req=0, viol_valid=1 logged. Second violation at 0x0200 does not overwrite viol_addr. viol_clr with simultaneous violation at 0x0201 -> viol_addr=0x0201.
5. Region 0 entered, then ins_addr moves to 0x0300 (region 1 entry) -> allow becomes 2'b10. Next-cycle access to 0x0210 violates, region=0.
6. With MCAM_VIOL_CNT_EN: 300 consecutive violating cycles -> viol_cnt=8'hFF. Without it, viol_cnt=0. Reset asserted in the 2nd PULSE cycle -> rst_req=0 next edge.
